// File: rtl/input_read_pkg.sv
// Shared field codes, FSM encoding and beat record for the input read sequencer.
package input_read_pkg;

  localparam logic [1:0] SEL_BIT  = 2'd0;
  localparam logic [1:0] SEL_NIB  = 2'd1;
  localparam logic [1:0] SEL_BYTE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_NIB  = 2'd2,
    ST_BYTE = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
  } beat_t;

  // Field carved from the FIFO head for a given state; all-zero when idle.
  function automatic beat_t extract(input state_t st, input logic [7:0] head);
    beat_t b;
    b = '0;
    unique case (st)
      ST_BIT:  begin b.sel = SEL_BIT;  b.data = {7'b0, head[3]};   end
      ST_NIB:  begin b.sel = SEL_NIB;  b.data = {4'b0, head[5:2]}; end
      ST_BYTE: begin b.sel = SEL_BYTE; b.data = head; b.last = 1'b1; end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/input_read_fifo.sv
// Small power-of-two FIFO; pointers wrap naturally, count disambiguates full/empty.
module input_read_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/input_read_seq.sv
// Splits each buffered byte into bit, nibble and byte field beats.
// Optional out_parity output enabled by defining INPUT_READ_SEQ_PARITY_EN.
module input_read_seq
  import input_read_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sel,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] byte_cnt
`ifdef INPUT_READ_SEQ_PARITY_EN
  ,
  output logic       out_parity
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state, state_nxt;
  beat_t         beat;
  logic          ready_en;
  logic          push, pop, hs;
  logic          full, empty;
  logic [7:0]    head;
  logic [CW-1:0] fifo_count;

  input_read_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // ready_en keeps in_ready low while in reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign in_ready  = ready_en && !full;
  assign push      = in_valid && in_ready;
  assign out_valid = (state != ST_IDLE);
  assign hs        = out_valid && out_ready;
  assign pop       = hs && (state == ST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) byte_cnt <= byte_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (!empty) state_nxt = ST_BIT;
      ST_BIT:  if (hs)     state_nxt = ST_NIB;
      ST_NIB:  if (hs)     state_nxt = ST_BYTE;
      // A same-cycle push counts as the next entry so bytes stream without a bubble.
      ST_BYTE: if (hs)     state_nxt = (fifo_count > CW'(1) || push) ? ST_BIT : ST_IDLE;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  // Fields depend only on state and FIFO head, both frozen during a stall.
  assign beat     = extract(state, head);
  assign out_sel  = beat.sel;
  assign out_data = beat.data;
  assign out_last = beat.last;

`ifdef INPUT_READ_SEQ_PARITY_EN
  assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_input_read_seq.sv
// Directed bench for input_read_seq: cycle table plus streaming, reset and wrap sequences.
module tb_input_read_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_sel;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] byte_cnt;
`ifdef INPUT_READ_SEQ_PARITY_EN
  logic       out_parity;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_read_seq #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_data  (out_data),
    .out_last  (out_last),
    .byte_cnt  (byte_cnt)
`ifdef INPUT_READ_SEQ_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ev;
    logic [1:0] es;
    logic [7:0] ed;
    logic       el;
    logic       eir;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[16];

  logic [7:0]  tx_q[$];
  logic [7:0]  sent_q[$];
  logic [10:0] rx_q[$];
  int          rx_cyc[$];
  logic [7:0]  cnt_hist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic ev, input logic [1:0] es, input logic [7:0] ed,
                              input logic el, input logic eir, input logic [7:0] ec);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.ev = ev; v.es = es;
    v.ed = ed; v.el = el; v.eir = eir; v.ec = ec;
    return v;
  endfunction

  // Expected beat k (0 bit, 1 nibble, 2 byte) of byte b, as {sel, data, last}.
  function automatic logic [10:0] model_beat(input logic [7:0] b, input int k);
    logic [10:0] r;
    if (k == 0)      r = {2'd0, 7'b0, b[3], 1'b0};
    else if (k == 1) r = {2'd1, 4'b0, b[5:2], 1'b0};
    else             r = {2'd2, b, 1'b1};
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Feeds tx_q whenever in_ready, accepts every beat, records beats and byte_cnt changes.
  task automatic stream(input int budget, input int n_beats, output int nr_cyc, output logic timeout);
    int cyc;
    logic [7:0] prev;
    cyc = 0; nr_cyc = 0; prev = byte_cnt;
    rx_q.delete(); rx_cyc.delete(); cnt_hist.delete(); sent_q.delete();
    while (rx_q.size() < n_beats && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (byte_cnt != prev) begin cnt_hist.push_back(byte_cnt); prev = byte_cnt; end
      out_ready = 1'b1;
      if (tx_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = tx_q[0];
        if (in_ready) sent_q.push_back(tx_q.pop_front());
        else nr_cyc++;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        rx_q.push_back({out_sel, out_data, out_last});
        rx_cyc.push_back(cyc);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (byte_cnt != prev) cnt_hist.push_back(byte_cnt);
    timeout = (cyc >= budget);
  endtask

  initial begin
    int nr, bad, first_bad;
    logic to;

    // Cycle table: outputs checked at negedge, then that row's inputs applied.
    tbl[0]  = mk(1, 8'hAC, 1, 0, 0, 8'h00, 0, 1, 0);
    tbl[1]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0);
    tbl[2]  = mk(0, 8'h00, 1, 1, 0, 8'h01, 0, 1, 0);
    tbl[3]  = mk(0, 8'h00, 1, 1, 1, 8'h0B, 0, 1, 0);
    tbl[4]  = mk(0, 8'h00, 1, 1, 2, 8'hAC, 1, 1, 0);
    tbl[5]  = mk(1, 8'h3C, 1, 0, 0, 8'h00, 0, 1, 1);
    tbl[6]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 1);
    tbl[7]  = mk(0, 8'h00, 1, 1, 0, 8'h01, 0, 1, 1);
    tbl[8]  = mk(0, 8'h55, 0, 1, 1, 8'h0F, 0, 1, 1);
    tbl[9]  = mk(0, 8'h66, 0, 1, 1, 8'h0F, 0, 1, 1);
    tbl[10] = mk(0, 8'h00, 0, 1, 1, 8'h0F, 0, 1, 1);
    tbl[11] = mk(0, 8'h00, 0, 1, 1, 8'h0F, 0, 1, 1);
    tbl[12] = mk(0, 8'h00, 0, 1, 1, 8'h0F, 0, 1, 1);
    tbl[13] = mk(0, 8'h00, 1, 1, 1, 8'h0F, 0, 1, 1);
    tbl[14] = mk(0, 8'h00, 1, 1, 2, 8'h3C, 1, 1, 1);
    tbl[15] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 2);

    // Reset state while rst_n is held low.
    #1;
    chk("reset_outputs", {out_valid, out_sel, out_data, out_last, in_ready, byte_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("row%0d", i),
          {out_valid, out_sel, out_data, out_last, in_ready, byte_cnt},
          {tbl[i].ev, tbl[i].es, tbl[i].ed, tbl[i].el, tbl[i].eir, tbl[i].ec});
`ifdef INPUT_READ_SEQ_PARITY_EN
      chk($sformatf("row%0d_parity", i), out_parity, ^tbl[i].ed);
`endif
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      @(negedge clk);
    end

    // Back-to-back 0x08, 0x20, 0xFF through a two-entry FIFO.
    tx_q = '{8'h08, 8'h20, 8'hFF};
    stream(100, 9, nr, to);
    chk("b2b_timeout", to, 1'b0);
    chk("b2b_beats", rx_q.size(), 9);
    if (rx_q.size() == 9) begin
      for (int i = 0; i < 9; i++)
        chk($sformatf("b2b_beat%0d", i), rx_q[i], model_beat(sent_q[i/3], i % 3));
      chk("b2b_no_gap", rx_cyc[8] - rx_cyc[0], 8);
    end
    chk("b2b_full_stall", nr, 3);
    chk("b2b_cnt", byte_cnt, 8'd5);

    // Async reset in the middle of a nibble beat with a second byte queued.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hAC;
    @(negedge clk);
    in_data = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_nib", {out_valid, out_sel, out_data}, {1'b1, 2'd1, 8'h0B});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {out_valid, out_sel, out_data, out_last, in_ready, byte_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_fifo_empty", {out_valid, in_ready}, 2'b01);
    end
    tx_q = '{8'h04};
    stream(50, 3, nr, to);
    chk("rst_restart_timeout", to, 1'b0);
    chk("rst_restart_beats", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("rst_restart_bit", rx_q[0], {2'd0, 8'h00, 1'b0});
      chk("rst_restart_nib", rx_q[1], {2'd1, 8'h01, 1'b0});
      chk("rst_restart_byte", rx_q[2], {2'd2, 8'h04, 1'b1});
    end
    repeat (3) @(negedge clk);
    chk("rst_no_leftover", {out_valid, byte_cnt}, {1'b0, 8'd1});

    // byte_cnt wrap over 256 streamed bytes.
    do_reset();
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i * 37 + 5));
    stream(1200, 768, nr, to);
    chk("wrap_timeout", to, 1'b0);
    chk("wrap_beats", rx_q.size(), 768);
    bad = 0; first_bad = -1;
    if (rx_q.size() == 768 && sent_q.size() == 256) begin
      for (int i = 0; i < 768; i++)
        if (rx_q[i] !== model_beat(sent_q[i/3], i % 3)) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      chk("wrap_no_gap", rx_cyc[767] - rx_cyc[0], 767);
    end else bad = -1;
    chk("wrap_beat_errors", bad, 0);
    chk("wrap_hist_len", cnt_hist.size(), 256);
    if (cnt_hist.size() == 256) begin
      chk("wrap_cnt_ff", cnt_hist[254], 8'hFF);
      chk("wrap_cnt_00", cnt_hist[255], 8'h00);
    end
    chk("wrap_final", {out_valid, byte_cnt}, {1'b0, 8'h00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
